// File: rtl/div_pkg.sv
// div_pkg: shared FSM state encoding and default width for the iterative divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int DIV_WIDTH_DEFAULT = 16;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring division step (shift in next dividend bit, trial subtract, quotient bit).
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_dvd_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic             o_q_bit
);
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  assign w_shift = {i_rem, i_dvd_bit};
  // One extra bit above the shifted remainder makes the borrow visible as the sign.
  assign w_diff  = w_shift - {2'b00, i_divisor};
  assign o_q_bit = ~w_diff[WIDTH+1];
  assign o_rem   = o_q_bit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
endmodule

// File: rtl/iter_divider.sv
// iter_divider: unsigned restoring divider, one quotient bit per clock, MSB first.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   w_rem;
  logic             w_q_bit;
  logic             w_accept;
  logic             w_last;
  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_dvd_bit (r_dvd[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem),
    .o_q_bit   (w_q_bit)
  );
  assign busy     = r_state == CALC;
  assign done     = r_state == DONE;
  assign w_accept = start && !busy;
  assign w_last   = r_cnt == CW'(WIDTH - 1);
  always_comb begin
    w_next = r_state;
    if (busy) w_next = w_last ? DONE : CALC;
    else      w_next = w_accept ? (divisor == '0 ? DONE : CALC) : IDLE;
  end
  // r_dvd doubles as the quotient shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept && divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend;
        div_zero  <= 1'b1;
      end else if (w_accept) begin
        r_cnt <= '0;
        r_rem <= '0;
        r_dvd <= dividend;
        r_dvs <= divisor;
      end else if (busy) begin
        r_cnt <= r_cnt + 1'b1;
        r_rem <= w_rem;
        r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
        if (w_last) begin
          quotient  <= {r_dvd[WIDTH-2:0], w_q_bit};
          remainder <= w_rem[WIDTH-1:0];
          div_zero  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: scoreboard bench for the 16-bit and 8-bit divider instances.
module tb_iter_divider;
  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          cyc;
  } exp_t;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start16 = 1'b0, start8 = 1'b0;
  logic [15:0] dd16 = '0, ds16 = '0;
  logic [7:0]  dd8 = '0, ds8 = '0;
  logic        busy16, done16, dz16, busy8, done8, dz8;
  logic [15:0] quo16, rem16;
  logic [7:0]  quo8, rem8;
  exp_t        sb16[$];
  exp_t        sb8[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  iter_divider u16 (
    .clk(clk), .rstn(rstn), .start(start16), .dividend(dd16), .divisor(ds16),
    .busy(busy16), .done(done16), .quotient(quo16), .remainder(rem16), .div_zero(dz16)
  );
  iter_divider #(.WIDTH(8)) u8 (
    .clk(clk), .rstn(rstn), .start(start8), .dividend(dd8), .divisor(ds8),
    .busy(busy8), .done(done8), .quotient(quo8), .remainder(rem8), .div_zero(dz8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (done16 === 1'b1) begin
      if (sb16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done16 actual=1 required=0");
      end else begin
        e = sb16.pop_front();
        chk("quotient16", 32'(quo16), 32'(e.q));
        chk("remainder16", 32'(rem16), 32'(e.r));
        chk("div_zero16", 32'(dz16), 32'(e.dz));
        chk("done_cycle16", cyc, e.cyc);
      end
    end
    if (done8 === 1'b1) begin
      if (sb8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8 actual=1 required=0");
      end else begin
        e = sb8.pop_front();
        chk("quotient8", 32'(quo8), 32'(e.q));
        chk("remainder8", 32'(rem8), 32'(e.r));
        chk("div_zero8", 32'(dz8), 32'(e.dz));
        chk("done_cycle8", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input bit w8, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input logic edz,
                       input bit push);
    exp_t e;
    @(negedge clk);
    if (w8) begin
      start8 = 1'b1; dd8 = a[7:0]; ds8 = b[7:0];
    end else begin
      start16 = 1'b1; dd16 = a; ds16 = b;
    end
    @(posedge clk);
    e.q   = eq;
    e.r   = er;
    e.dz  = edz;
    e.cyc = cyc + (edz ? 1 : (w8 ? 9 : 17));
    if (push && w8) sb8.push_back(e);
    if (push && !w8) sb16.push_back(e);
    #1;
    start8  = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic wait_all();
    for (int i = 0; i < 100 && (sb16.size() != 0 || sb8.size() != 0); i++) @(negedge clk);
    if (sb16.size() != 0 || sb8.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d required=0 pending", sb16.size() + sb8.size());
      sb16.delete();
      sb8.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_busy16", 32'(busy16), 0);
    chk("rst_done16", 32'(done16), 0);
    chk("rst_quotient16", 32'(quo16), 0);
    chk("rst_remainder16", 32'(rem16), 0);
    chk("rst_div_zero16", 32'(dz16), 0);
    @(negedge clk);
    rstn = 1'b1;
    issue(0, 100, 50, 2, 0, 0, 1);
    @(negedge clk);
    chk("busy16_in_calc", 32'(busy16), 1);
    wait_all();
    issue(0, 17, 5, 3, 2, 0, 1);
    repeat (16) @(posedge clk);
    issue(0, 65535, 256, 255, 255, 0, 1);
    wait_all();
    issue(0, 100, 0, 65535, 100, 1, 1);
    issue(0, 1, 1, 1, 0, 0, 1);
    wait_all();
    issue(0, 12345, 67, 184, 17, 0, 1);
    repeat (5) @(posedge clk);
    #1;
    start16 = 1'b1; dd16 = 5; ds16 = 10;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    wait_all();
    dd16 = 999; ds16 = 3;
    repeat (4) @(negedge clk);
    chk("hold_quotient16", 32'(quo16), 184);
    chk("hold_remainder16", 32'(rem16), 17);
    chk("hold_div_zero16", 32'(dz16), 0);
    chk("hold_done16", 32'(done16), 0);
    issue(0, 789, 12, 0, 0, 0, 0);
    repeat (7) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_busy16", 32'(busy16), 0);
    chk("async_rst_quotient16", 32'(quo16), 0);
    chk("async_rst_remainder16", 32'(rem16), 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_busy16", 32'(busy16), 0);
    issue(0, 54321, 123, 441, 78, 0, 1);
    wait_all();
    issue(1, 200, 15, 13, 5, 0, 1);
    wait_all();
    issue(1, 255, 255, 1, 0, 0, 1);
    wait_all();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
